// File: rtl/alu_pkg.sv
// Shared ALU definitions: widths, funct3 opcodes, compare codes and arbiter states.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 16;
  localparam int unsigned ALU_F3W   = 3;

  // ALU operation select (funct3)
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_AND = 3'd4;
  localparam logic [2:0] ALU_SLL = 3'd5;
  localparam logic [2:0] ALU_SRL = 3'd6;
  localparam logic [2:0] ALU_SRA = 3'd7;

  // Compare-flag meaning, selected by funct3[1:0]
  localparam logic [1:0] CMP_EQ = 2'd0;
  localparam logic [1:0] CMP_NE = 2'd1;
  localparam logic [1:0] CMP_LT = 2'd2;
  localparam logic [1:0] CMP_GE = 2'd3;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the port
// that was not granted last.
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o,
  output logic       grant_idx_o
);

  // Pick the winning index, then one-hot it when anyone is requesting
  always_comb begin
    grant_idx_o = 1'b0;
    grant_o     = 2'b00;
    unique case (valid_i)
      2'b01:   grant_idx_o = 1'b0;
      2'b10:   grant_idx_o = 1'b1;
      2'b11:   grant_idx_o = ~last_grant_i;
      default: grant_idx_o = 1'b0;
    endcase
    if (valid_i != 2'b00) begin
      grant_o = grant_idx_o ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external ALU between the datapath (port 0) and the PC/address
// incrementer (port 1). Operands and results are registered so the ALU sits
// on a register-to-register path; one operation is in flight at a time.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned F3W   = ALU_F3W
) (
  input  logic             clk,
  input  logic             rst_n,
  // port 0: main datapath
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [F3W-1:0]   req0_funct3,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_cmp,
  // port 1: PC/address increment
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [F3W-1:0]   req1_funct3,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_cmp,
  // shared ALU
  output logic [F3W-1:0]   alu_funct3,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_cmp
);

  arb_state_e       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [F3W-1:0]   funct3_q, funct3_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             rsp0_valid_q, rsp0_valid_d;
  logic [WIDTH-1:0] rsp0_result_q, rsp0_result_d;
  logic             rsp0_cmp_q, rsp0_cmp_d;
  logic             rsp1_valid_q, rsp1_valid_d;
  logic [WIDTH-1:0] rsp1_result_q, rsp1_result_d;
  logic             rsp1_cmp_q, rsp1_cmp_d;

  logic [1:0] grant;
  logic       grant_idx;
  logic       idle;
  logic       accept;
  logic       owner_rsp_ready;

  rr_arb2 u_rr_arb2 (
    .valid_i      ({req1_valid, req0_valid}),
    .last_grant_i (last_grant_q),
    .grant_o      (grant),
    .grant_idx_o  (grant_idx)
  );

  assign idle            = (state_q == ST_IDLE);
  assign req0_ready      = idle && grant[0];
  assign req1_ready      = idle && grant[1];
  assign accept          = idle && (grant != 2'b00);
  assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

  // State, operand and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= 1'b1;
      owner_q       <= 1'b0;
      funct3_q      <= '0;
      opa_q         <= '0;
      opb_q         <= '0;
      rsp0_valid_q  <= 1'b0;
      rsp0_result_q <= '0;
      rsp0_cmp_q    <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp1_result_q <= '0;
      rsp1_cmp_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      owner_q       <= owner_d;
      funct3_q      <= funct3_d;
      opa_q         <= opa_d;
      opb_q         <= opb_d;
      rsp0_valid_q  <= rsp0_valid_d;
      rsp0_result_q <= rsp0_result_d;
      rsp0_cmp_q    <= rsp0_cmp_d;
      rsp1_valid_q  <= rsp1_valid_d;
      rsp1_result_q <= rsp1_result_d;
      rsp1_cmp_q    <= rsp1_cmp_d;
    end
  end

  // Sequencing: accept in IDLE, capture ALU result after one EXEC cycle,
  // hold the response until the owner takes it
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    owner_d       = owner_q;
    funct3_d      = funct3_q;
    opa_d         = opa_q;
    opb_d         = opb_q;
    rsp0_valid_d  = rsp0_valid_q;
    rsp0_result_d = rsp0_result_q;
    rsp0_cmp_d    = rsp0_cmp_q;
    rsp1_valid_d  = rsp1_valid_q;
    rsp1_result_d = rsp1_result_q;
    rsp1_cmp_d    = rsp1_cmp_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          funct3_d     = grant_idx ? req1_funct3 : req0_funct3;
          opa_d        = grant_idx ? req1_a      : req0_a;
          opb_d        = grant_idx ? req1_b      : req0_b;
          owner_d      = grant_idx;
          last_grant_d = grant_idx;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (owner_q) begin
          rsp1_result_d = alu_out;
          rsp1_cmp_d    = alu_cmp;
          rsp1_valid_d  = 1'b1;
        end else begin
          rsp0_result_d = alu_out;
          rsp0_cmp_d    = alu_cmp;
          rsp0_valid_d  = 1'b1;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (owner_rsp_ready) begin
          if (owner_q) begin
            rsp1_valid_d = 1'b0;
          end else begin
            rsp0_valid_d = 1'b0;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign alu_funct3  = funct3_q;
  assign alu_a       = opa_q;
  assign alu_b       = opb_q;
  assign rsp0_valid  = rsp0_valid_q;
  assign rsp0_result = rsp0_result_q;
  assign rsp0_cmp    = rsp0_cmp_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp1_result = rsp1_result_q;
  assign rsp1_cmp    = rsp1_cmp_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: behavioural ALU stub, transaction-level
// reference model checked every cycle, and directed scenarios with literal
// expectations.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int unsigned W = ALU_WIDTH;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_cmp;
  logic [2:0]   req0_funct3;
  logic [W-1:0] req0_a, req0_b, rsp0_result;
  logic         req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_cmp;
  logic [2:0]   req1_funct3;
  logic [W-1:0] req1_a, req1_b, rsp1_result;
  logic [2:0]   alu_funct3;
  logic [W-1:0] alu_a, alu_b, alu_out;
  logic         alu_cmp;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_share_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_funct3 (req0_funct3),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .rsp0_valid  (rsp0_valid),
    .rsp0_ready  (rsp0_ready),
    .rsp0_result (rsp0_result),
    .rsp0_cmp    (rsp0_cmp),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_funct3 (req1_funct3),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .rsp1_valid  (rsp1_valid),
    .rsp1_ready  (rsp1_ready),
    .rsp1_result (rsp1_result),
    .rsp1_cmp    (rsp1_cmp),
    .alu_funct3  (alu_funct3),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_out     (alu_out),
    .alu_cmp     (alu_cmp)
  );

  // Reference ALU: {cmp, result}; cmp meaning chosen by funct3[1:0]
  function automatic logic [W:0] alu_ref(input logic [2:0] f, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [W-1:0] r;
    logic         c;
    case (f)
      ALU_ADD: r = W'(a + b);
      ALU_SUB: r = W'(a - b);
      ALU_XOR: r = a ^ b;
      ALU_OR:  r = a | b;
      ALU_AND: r = a & b;
      ALU_SLL: r = a << b[3:0];
      ALU_SRL: r = a >> b[3:0];
      default: r = W'($signed(a) >>> b[3:0]);
    endcase
    case (f[1:0])
      CMP_EQ:  c = (a == b);
      CMP_NE:  c = (a != b);
      CMP_LT:  c = ($signed(a) < $signed(b));
      default: c = ($signed(a) >= $signed(b));
    endcase
    return {c, r};
  endfunction

  // External ALU stand-in
  always_comb {alu_cmp, alu_out} = alu_ref(alu_funct3, alu_a, alu_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: at most one op outstanding; its response is
  // visible from two cycles after acceptance until the owner takes it.
  int unsigned  m_cyc = 0;
  int unsigned  m_issue = 0;
  logic         m_pend = 1'b0;
  logic         m_port = 1'b0;
  logic         m_last = 1'b1;
  logic [W-1:0] m_pres = '0;
  logic         m_pcmp = 1'b0;
  logic [2:0]   m_f = '0;
  logic [W-1:0] m_a = '0, m_b = '0;
  logic [W-1:0] h_res [2] = '{'0, '0};
  logic         h_cmp [2] = '{1'b0, 1'b0};

  // Compare DUT against the model each cycle, then advance the model
  always @(negedge clk) begin : model
    logic e_r0, e_r1, vis, hs;
    logic [W:0] g;
    m_cyc++;
    if (!rst_n) begin
      m_pend = 1'b0; m_last = 1'b1; m_f = '0; m_a = '0; m_b = '0;
      h_res[0] = '0; h_res[1] = '0; h_cmp[0] = 1'b0; h_cmp[1] = 1'b0;
    end else if (m_pend && m_cyc == m_issue + 2) begin
      h_res[m_port] = m_pres;
      h_cmp[m_port] = m_pcmp;
    end
    vis  = rst_n && m_pend && (m_cyc >= m_issue + 2);
    e_r0 = 1'b0;
    e_r1 = 1'b0;
    if (rst_n && !m_pend) begin
      if (req0_valid && (!req1_valid || m_last)) e_r0 = 1'b1;
      else if (req1_valid) e_r1 = 1'b1;
    end
    chk("m_req0_ready", 32'(req0_ready), 32'(e_r0));
    chk("m_req1_ready", 32'(req1_ready), 32'(e_r1));
    chk("m_rsp0_valid", 32'(rsp0_valid), 32'(vis && !m_port));
    chk("m_rsp1_valid", 32'(rsp1_valid), 32'(vis && m_port));
    chk("m_rsp0_result", 32'(rsp0_result), 32'(h_res[0]));
    chk("m_rsp1_result", 32'(rsp1_result), 32'(h_res[1]));
    chk("m_rsp0_cmp", 32'(rsp0_cmp), 32'(h_cmp[0]));
    chk("m_rsp1_cmp", 32'(rsp1_cmp), 32'(h_cmp[1]));
    chk("m_alu_funct3", 32'(alu_funct3), 32'(m_f));
    chk("m_alu_a", 32'(alu_a), 32'(m_a));
    chk("m_alu_b", 32'(alu_b), 32'(m_b));
    hs = vis && (m_port ? rsp1_ready : rsp0_ready);
    if (hs) begin
      m_pend = 1'b0;
    end else if (e_r0 || e_r1) begin
      m_pend  = 1'b1;
      m_port  = e_r1;
      m_last  = e_r1;
      m_issue = m_cyc;
      m_f     = e_r1 ? req1_funct3 : req0_funct3;
      m_a     = e_r1 ? req1_a : req0_a;
      m_b     = e_r1 ? req1_b : req0_b;
      g       = alu_ref(m_f, m_a, m_b);
      m_pres  = g[W-1:0];
      m_pcmp  = g[W];
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drv0(input logic v, input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    req0_valid = v; req0_funct3 = f; req0_a = a; req0_b = b;
  endtask

  task automatic drv1(input logic v, input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    req1_valid = v; req1_funct3 = f; req1_a = a; req1_b = b;
  endtask

  task automatic pulse_reset();
    nxt();
    rst_n = 1'b0;
    drv0(1'b0, 3'd0, '0, '0);
    drv1(1'b0, 3'd0, '0, '0);
    nxt();
    nxt();
    rst_n = 1'b1;
  endtask

  logic [2:0]   s_f   [3] = '{ALU_ADD, ALU_SLL, ALU_OR};
  logic [W-1:0] s_a   [3] = '{16'd1, 16'd1, 16'h000F};
  logic [W-1:0] s_b   [3] = '{16'd1, 16'd4, 16'h00F0};
  logic [W-1:0] s_exp [3] = '{16'd2, 16'd16, 16'h00FF};
  int unsigned  acc_cyc [3];

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : directed
    int n;
    rst_n = 1'b0;
    drv0(1'b0, 3'd0, '0, '0);
    drv1(1'b0, 3'd0, '0, '0);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    nxt(); nxt();
    smp();
    chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    nxt();
    rst_n = 1'b1;

    // Single request on port 0
    drv0(1'b1, ALU_ADD, 16'd5, 16'd3);
    smp();
    chk("t1_req0_ready", 32'(req0_ready), 32'd1);
    chk("t1_req1_ready", 32'(req1_ready), 32'd0);
    nxt(); drv0(1'b0, 3'd0, '0, '0);
    smp();
    chk("t1_exec_rsp0_valid", 32'(rsp0_valid), 32'd0);
    nxt(); smp();
    chk("t1_rsp0_valid", 32'(rsp0_valid), 32'd1);
    chk("t1_rsp0_result", 32'(rsp0_result), 32'd8);
    chk("t1_rsp0_cmp", 32'(rsp0_cmp), 32'd0);
    chk("t1_rsp1_valid", 32'(rsp1_valid), 32'd0);
    chk("t1_rsp1_result", 32'(rsp1_result), 32'd0);
    nxt(); smp();
    chk("t1_done_rsp0_valid", 32'(rsp0_valid), 32'd0);

    // Tie after reset: port 0, then port 1, then port 0 again
    pulse_reset();
    drv0(1'b1, ALU_SUB, 16'd10, 16'd4);
    drv1(1'b1, ALU_XOR, 16'hFFFF, 16'd1);
    smp();
    chk("t2_first_req0_ready", 32'(req0_ready), 32'd1);
    chk("t2_first_req1_ready", 32'(req1_ready), 32'd0);
    nxt(); nxt(); smp();
    chk("t2_rsp0_valid", 32'(rsp0_valid), 32'd1);
    chk("t2_rsp0_result", 32'(rsp0_result), 32'd6);
    nxt(); smp();
    chk("t2_second_req1_ready", 32'(req1_ready), 32'd1);
    nxt(); nxt(); smp();
    chk("t2_rsp1_valid", 32'(rsp1_valid), 32'd1);
    chk("t2_rsp1_result", 32'(rsp1_result), 32'hFFFE);
    chk("t2_rsp1_cmp", 32'(rsp1_cmp), 32'd1);
    nxt(); smp();
    chk("t2_third_req0_ready", 32'(req0_ready), 32'd1);
    nxt();
    drv0(1'b0, 3'd0, '0, '0);
    drv1(1'b0, 3'd0, '0, '0);
    nxt(); nxt();

    // Backpressure on port 1 while port 0 waits
    drv1(1'b1, ALU_SRA, 16'hFFF0, 16'd2);
    rsp1_ready = 1'b0;
    smp();
    chk("t3_req1_ready", 32'(req1_ready), 32'd1);
    nxt();
    drv1(1'b0, 3'd0, '0, '0);
    drv0(1'b1, ALU_ADD, 16'd1, 16'd1);
    smp();
    chk("t3_exec_req0_ready", 32'(req0_ready), 32'd0);
    nxt();
    for (int i = 0; i < 5; i++) begin
      smp();
      chk("t3_hold_rsp1_valid", 32'(rsp1_valid), 32'd1);
      chk("t3_hold_rsp1_result", 32'(rsp1_result), 32'hFFFC);
      chk("t3_hold_rsp1_cmp", 32'(rsp1_cmp), 32'd0);
      chk("t3_hold_req0_ready", 32'(req0_ready), 32'd0);
      nxt();
    end
    rsp1_ready = 1'b1;
    smp();
    chk("t3_release_rsp1_valid", 32'(rsp1_valid), 32'd1);
    nxt(); smp();
    chk("t3_after_rsp1_valid", 32'(rsp1_valid), 32'd0);
    chk("t3_after_req0_ready", 32'(req0_ready), 32'd1);
    nxt();
    drv0(1'b0, 3'd0, '0, '0);
    nxt(); nxt();

    // Reset during EXEC discards the op
    drv0(1'b1, ALU_AND, 16'h00FF, 16'h0F0F);
    smp();
    chk("t4_req0_ready", 32'(req0_ready), 32'd1);
    nxt();
    drv0(1'b0, 3'd0, '0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_async_rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("t4_async_rsp0_result", 32'(rsp0_result), 32'd0);
    chk("t4_async_alu_funct3", 32'(alu_funct3), 32'd0);
    chk("t4_async_alu_a", 32'(alu_a), 32'd0);
    chk("t4_async_alu_b", 32'(alu_b), 32'd0);
    nxt();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("t4_no_rsp0_valid", 32'(rsp0_valid), 32'd0);
      nxt();
    end
    drv0(1'b1, ALU_ADD, 16'd2, 16'd2);
    drv1(1'b1, ALU_ADD, 16'd3, 16'd3);
    smp();
    chk("t4_tie_req0_ready", 32'(req0_ready), 32'd1);
    chk("t4_tie_req1_ready", 32'(req1_ready), 32'd0);
    nxt();
    drv0(1'b0, 3'd0, '0, '0);
    drv1(1'b0, 3'd0, '0, '0);
    nxt(); nxt();

    // Streaming from port 0 alone
    for (int k = 0; k < 3; k++) begin
      drv0(1'b1, s_f[k], s_a[k], s_b[k]);
      n = 0;
      smp();
      while (!req0_ready && n < 10) begin
        nxt(); smp(); n++;
      end
      chk("t5_accept_wait", 32'(n < 10), 32'd1);
      acc_cyc[k] = cyc;
      nxt();
      if (k == 2) drv0(1'b0, 3'd0, '0, '0);
      smp(); nxt(); smp();
      chk("t5_rsp0_valid", 32'(rsp0_valid), 32'd1);
      chk("t5_rsp0_result", 32'(rsp0_result), 32'(s_exp[k]));
      nxt();
    end
    chk("t5_gap01", acc_cyc[1] - acc_cyc[0], 32'd3);
    chk("t5_gap12", acc_cyc[2] - acc_cyc[1], 32'd3);

    // Strict alternation with both ports always valid
    pulse_reset();
    drv0(1'b1, ALU_ADD, 16'h0100, 16'h0023);
    drv1(1'b1, ALU_XOR, 16'h5A5A, 16'h0FF0);
    for (int k = 0; k < 6; k++) begin
      n = 0;
      smp();
      while (!(req0_ready || req1_ready) && n < 10) begin
        nxt(); smp(); n++;
      end
      chk("t6_accept_wait", 32'(n < 10), 32'd1);
      chk("t6_grant_port", 32'(req1_ready), 32'(k % 2));
      nxt();
      if (k == 5) begin
        drv0(1'b0, 3'd0, '0, '0);
        drv1(1'b0, 3'd0, '0, '0);
      end
      smp(); nxt(); smp();
      if (k % 2 == 0) begin
        chk("t6_rsp0_valid", 32'(rsp0_valid), 32'd1);
        chk("t6_rsp0_result", 32'(rsp0_result), 32'h0123);
        chk("t6_rsp1_quiet", 32'(rsp1_valid), 32'd0);
      end else begin
        chk("t6_rsp1_valid", 32'(rsp1_valid), 32'd1);
        chk("t6_rsp1_result", 32'(rsp1_result), 32'h55AA);
        chk("t6_rsp0_quiet", 32'(rsp0_valid), 32'd0);
      end
      nxt();
    end
    nxt(); nxt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
